// File: rtl/id_operand_stage.sv
// Decode-side operand stage: priority forwarding, load-use interlock and the ID/EX latch.
// Optional feature: define ID_STALL_CNT_EN to add the saturating load-use stall counter (stall_cnt_o).
module id_operand_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_RD  = 2,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [NUM_RD-1:0]         rd_en_i,
    input  logic [NUM_RD*ADDR_W-1:0]  rd_addr_i,
    input  logic [NUM_RD*DATA_W-1:0]  rf_data_i,
    input  logic [DATA_W-1:0]         imm_i,
    input  logic [NUM_FWD-1:0]        fwd_we_i,
    input  logic [NUM_FWD*ADDR_W-1:0] fwd_wd_i,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
    input  logic                      fwd_load_i,
    input  logic                      flush_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [NUM_RD*DATA_W-1:0]  op_o,
    output logic                      stall_o
`ifdef ID_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]          stall_cnt_o
`endif
);

    typedef enum logic {RUN, LU_STALL} state_t;

    state_t                     state;
    logic [NUM_RD*DATA_W-1:0]   op_next;
    logic [ADDR_W-1:0]          src_addr;
    logic [DATA_W-1:0]          src_data;
    logic                       hazard;
    logic                       adv;

    // Operand select: walking from the oldest source down lets the youngest match win.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        op_next  = '0;
        src_addr = '0;
        src_data = '0;
        hazard   = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            src_addr = rd_addr_i[p*ADDR_W +: ADDR_W];
            src_data = rf_data_i[p*DATA_W +: DATA_W];
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (fwd_we_i[k] && (fwd_wd_i[k*ADDR_W +: ADDR_W] == src_addr))
                    src_data = fwd_wdata_i[k*DATA_W +: DATA_W];
            end
            if (src_addr == '0)
                src_data = '0;
            if (!rd_en_i[p])
                src_data = imm_i;
            op_next[p*DATA_W +: DATA_W] = src_data;

            // A load in EX has no data yet, so any real read of its destination must wait.
            if (rd_en_i[p] && (src_addr != '0) && (src_addr == fwd_wd_i[0 +: ADDR_W]))
                hazard = in_valid_i & fwd_load_i & fwd_we_i[0];
        end
    end

    assign adv        = !out_valid_o || out_ready_i;
    assign in_ready_o = adv && !hazard && !flush_i;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            out_valid_o <= 1'b0;
            op_o        <= '0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (adv) begin
            if (hazard) begin
                out_valid_o <= 1'b0;
            end else begin
                out_valid_o <= in_valid_i;
                if (in_valid_i)
                    op_o <= op_next;
            end
        end
    end

    // Interlock FSM; stall_o is registered alongside the state it mirrors.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            stall_o <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (!flush_i && hazard && adv) begin
                        state   <= LU_STALL;
                        stall_o <= 1'b1;
                    end
                end
                LU_STALL: begin
                    if (flush_i || !hazard) begin
                        state   <= RUN;
                        stall_o <= 1'b0;
                    end
                end
                default: begin
                    state   <= RUN;
                    stall_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef ID_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_o <= '0;
        else if ((state == LU_STALL) && (stall_cnt_o != '1))
            stall_cnt_o <= stall_cnt_o + 1'b1;
    end
`endif

endmodule
